alu_control_seq: RTL

- Registered, handshaked successor to the combinational ALU control decoder. Sits between instruction decode and execute.
- Decodes func3/func7/aluop into an alu_t ALU operation, as before.
- Adds RV32M decode (func7 = 7'b0000001) and illegal-encoding detection.
- Adds a latency sequencer that holds the stage busy for parametrised multiply/divide cycle counts before presenting the result downstream.

---
 rtl/alu_control_seq_if.sv | 33 +++
 rtl/alu_control_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq_if.sv
// Decode-to-execute bundle for alu_control_seq: upstream op handshake,
// downstream decoded-op handshake, MDU sideband and FSM state for checkers.
interface alu_control_seq_if;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [1:0] aluop;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] aluctr;
    logic       is_mdu;
    logic [2:0] mdu_op;
    logic       mdu_start;
    logic       illegal;
    logic       busy;
    logic [1:0] fsm_state;

    // Valid/ready: a transfer happens on a rising clk edge where valid and
    // ready are both high; once raised, valid and its payload hold until then.
    modport master (
        output flush, in_valid, func3, func7, aluop, out_ready,
        input  in_ready, out_valid, aluctr, is_mdu, mdu_op, mdu_start,
               illegal, busy, fsm_state
    );

    modport slave (
        input  flush, in_valid, func3, func7, aluop, out_ready,
        output in_ready, out_valid, aluctr, is_mdu, mdu_op, mdu_start,
               illegal, busy, fsm_state
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with RV32M decode, illegal-encoding flagging
// and a multiply/divide latency sequencer between decode and execute.
module alu_control_seq #(
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input logic              clk,
    input logic              rst_n,
    alu_control_seq_if.slave bus
);
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE = 2'd2;
    localparam logic [1:0] ALUOP_ITYPE = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        MDU_BUSY = 2'd2
    } state_t;

    state_t           state;
    logic             out_valid_q;
    logic [3:0]       aluctr_q;
    logic             is_mdu_q;
    logic [2:0]       mdu_op_q;
    logic             mdu_start_q;
    logic             illegal_q;
    logic             busy_q;
    logic [CNT_W-1:0] count;

    logic [3:0] base_alu;
    logic [3:0] dec_alu;
    logic       dec_mdu;
    logic       dec_ill;
    logic       in_ready_c;
    logic       accept;

    always_comb begin
        base_alu = ALU_ADD;
        case (bus.func3)
            3'b000: base_alu = ALU_ADD;
            3'b001: base_alu = ALU_SLL;
            3'b010: base_alu = ALU_SLT;
            3'b011: base_alu = ALU_SLTU;
            3'b100: base_alu = ALU_XOR;
            3'b101: base_alu = ALU_SRL;
            3'b110: base_alu = ALU_OR;
            3'b111: base_alu = ALU_AND;
        endcase
    end

    // Illegal and MDU ops leave dec_alu at ALU_ADD so execute never sees junk.
    always_comb begin
        dec_alu = ALU_ADD;
        dec_mdu = 1'b0;
        dec_ill = 1'b0;
        case (bus.aluop)
            ALUOP_ADD: dec_alu = ALU_ADD;
            ALUOP_SUB: dec_alu = ALU_SUB;
            ALUOP_RTYPE: begin
                if (bus.func7 == F7_BASE) begin
                    dec_alu = base_alu;
                end else if (bus.func7 == F7_ALT) begin
                    if (bus.func3 == 3'b000)      dec_alu = ALU_SUB;
                    else if (bus.func3 == 3'b101) dec_alu = ALU_SRA;
                    else                          dec_ill = 1'b1;
                end else if (bus.func7 == F7_MULDIV && ENABLE_M) begin
                    dec_mdu = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: begin
                if (bus.func3 == 3'b101) begin
                    if (bus.func7 == F7_ALT)       dec_alu = ALU_SRA;
                    else if (bus.func7 == F7_BASE) dec_alu = ALU_SRL;
                    else                           dec_ill = 1'b1;
                end else if (bus.func3 == 3'b001 && bus.func7 != F7_BASE) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_alu = base_alu;
                end
            end
        endcase
    end

    // HOLD forwards out_ready so a consumed op can be replaced in the same cycle.
    always_comb begin
        in_ready_c = 1'b0;
        if (rst_n && !bus.flush) begin
            case (state)
                IDLE:    in_ready_c = 1'b1;
                HOLD:    in_ready_c = bus.out_ready;
                default: in_ready_c = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid && in_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            aluctr_q    <= ALU_ADD;
            is_mdu_q    <= 1'b0;
            mdu_op_q    <= 3'd0;
            mdu_start_q <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            count       <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            mdu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            count       <= '0;
        end else begin
            mdu_start_q <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        aluctr_q  <= dec_alu;
                        is_mdu_q  <= dec_mdu;
                        mdu_op_q  <= dec_mdu ? bus.func3 : 3'd0;
                        illegal_q <= dec_ill;
                        if (dec_mdu) begin
                            state       <= MDU_BUSY;
                            out_valid_q <= 1'b0;
                            mdu_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                            count       <= bus.func3[2] ? DIV_LOAD : MUL_LOAD;
                        end else begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end else if (state == HOLD && bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                MDU_BUSY: begin
                    if (count == '0) begin
                        state       <= HOLD;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.aluctr    = aluctr_q;
    assign bus.is_mdu    = is_mdu_q;
    assign bus.mdu_op    = mdu_op_q;
    assign bus.mdu_start = mdu_start_q;
    assign bus.illegal   = illegal_q;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;
endmodule
